ecc_scalar_mult_ctrl: RTL and testbench

ECC_SCALAR_MULT_CTRL -- requirements
Module: ecc_scalar_mult_ctrl

---
 rtl/ecc_pkg.sv | 18 +
 rtl/ecc_scalar_mult_ctrl.sv | 152 +++++++++++++++
 tb/tb_ecc_scalar_mult_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the scalar-multiplication controller and the external group-op unit.
package ecc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DBL_REQ,
        DBL_WAIT,
        ADD_REQ,
        ADD_WAIT,
        NEXT,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_DBL = 1'b1;

endpackage

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P; point arithmetic is delegated
// to an external group-op unit over a single-outstanding request/done handshake.
module ecc_scalar_mult_ctrl
    import ecc_pkg::*;
#(
    parameter int n = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] k,
    input  logic [n-1:0] p,
    input  logic [n-1:0] px,
    input  logic [n-1:0] py,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] qx,
    output logic [n-1:0] qy,
    output logic         q_inf,
    output logic         op_req,
    output logic         op_sel,
    output logic [n-1:0] op_p,
    output logic [n-1:0] op_x1,
    output logic [n-1:0] op_y1,
    output logic [n-1:0] op_x2,
    output logic [n-1:0] op_y2,
    input  logic         op_done,
    input  logic [n-1:0] op_x3,
    input  logic [n-1:0] op_y3,
    input  logic         op_inf
);

    localparam int IW = (n > 1) ? $clog2(n) : 1;

    state_t         state, state_nx;
    logic [n-1:0]   k_r, p_r, px_r, py_r;
    logic [n-1:0]   rx, ry;
    logic           r_inf;
    logic [IW-1:0]  idx;
    logic           k_bit;
    logic           x_eq, y_eq;

    assign k_bit = k_r[idx];
    assign x_eq  = (rx == px_r);
    assign y_eq  = (ry == py_r);
    assign op_p  = p_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = LOAD;
            LOAD:     state_nx = DBL_REQ;
            DBL_REQ:  state_nx = r_inf ? (k_bit ? ADD_REQ : NEXT) : DBL_WAIT;
            DBL_WAIT: if (op_done) state_nx = k_bit ? ADD_REQ : NEXT;
            // R = P with R infinite and R = -P are resolved locally without the unit
            ADD_REQ:  state_nx = (r_inf || (x_eq && !y_eq)) ? NEXT : ADD_WAIT;
            ADD_WAIT: if (op_done) state_nx = NEXT;
            NEXT:     state_nx = (idx == '0) ? DONE : DBL_REQ;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r    <= '0;
            p_r    <= '0;
            px_r   <= '0;
            py_r   <= '0;
            rx     <= '0;
            ry     <= '0;
            r_inf  <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            qx     <= '0;
            qy     <= '0;
            q_inf  <= 1'b0;
            op_req <= 1'b0;
            op_sel <= 1'b0;
            op_x1  <= '0;
            op_y1  <= '0;
            op_x2  <= '0;
            op_y2  <= '0;
        end else begin
            op_req <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    k_r   <= k;
                    p_r   <= p;
                    px_r  <= px;
                    py_r  <= py;
                    rx    <= '0;
                    ry    <= '0;
                    r_inf <= 1'b1;
                    idx   <= IW'(n - 1);
                    busy  <= 1'b1;
                end
                DBL_REQ: if (!r_inf) begin
                    op_req <= 1'b1;
                    op_sel <= OP_DBL;
                    op_x1  <= rx;
                    op_y1  <= ry;
                end
                DBL_WAIT, ADD_WAIT: if (op_done) begin
                    rx    <= op_x3;
                    ry    <= op_y3;
                    r_inf <= op_inf;
                end
                ADD_REQ: begin
                    if (r_inf) begin
                        rx    <= px_r;
                        ry    <= py_r;
                        r_inf <= 1'b0;
                    end else if (x_eq && y_eq) begin
                        op_req <= 1'b1;
                        op_sel <= OP_DBL;
                        op_x1  <= rx;
                        op_y1  <= ry;
                    end else if (x_eq) begin
                        rx    <= '0;
                        ry    <= '0;
                        r_inf <= 1'b1;
                    end else begin
                        op_req <= 1'b1;
                        op_sel <= OP_ADD;
                        op_x1  <= rx;
                        op_y1  <= ry;
                        op_x2  <= px_r;
                        op_y2  <= py_r;
                    end
                end
                NEXT: if (idx != '0) idx <= idx - 1'b1;
                DONE: begin
                    qx    <= r_inf ? '0 : rx;
                    qy    <= r_inf ? '0 : ry;
                    q_inf <= r_inf;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl on y^2 = x^3 + 2x + 2 mod 17, P = (5,1), with a
// behavioural group-op responder of random latency.
module tb_ecc_scalar_mult_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] k_in;
    logic [N-1:0] p_in, px_in, py_in;
    logic         busy, done, q_inf, op_req, op_sel;
    logic [N-1:0] qx, qy, op_p, op_x1, op_y1, op_x2, op_y2;
    logic         op_done, resp_done, spur_done;
    logic [N-1:0] op_x3, op_y3;
    logic         op_inf;

    assign op_done = resp_done | spur_done;

    ecc_scalar_mult_ctrl #(.n(N)) dut (
        .clk(clk), .reset(reset), .start(start), .k(k_in), .p(p_in),
        .px(px_in), .py(py_in), .busy(busy), .done(done), .qx(qx), .qy(qy),
        .q_inf(q_inf), .op_req(op_req), .op_sel(op_sel), .op_p(op_p),
        .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2),
        .op_done(op_done), .op_x3(op_x3), .op_y3(op_y3), .op_inf(op_inf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int md(input int a);
        return ((a % 17) + 17) % 17;
    endfunction

    function automatic int inv(input int a);
        for (int i = 1; i < 17; i++)
            if (md(a * i) == 1) return i;
        return 0;
    endfunction

    // Responder state shared with the main sequence
    int           req_cnt = 0;
    logic [7:0]   sel_log = '0;
    int           stab_err = 0;
    int           min_lat = 1;
    bit           resp_busy = 0;
    bit           in_rst_test = 0;
    logic [N-1:0] last_x2, last_y2;

    initial begin
        int x1, y1, x2, y2, l, x3, y3, lat;
        logic s, inf;
        logic [N-1:0] cx1, cy1, cx2, cy2, cp;
        resp_done = 1'b0;
        op_x3 = '0;
        op_y3 = '0;
        op_inf = 1'b0;
        forever begin
            @(negedge clk);
            if (op_req === 1'b1) begin
                resp_busy = 1;
                req_cnt++;
                s = op_sel;
                sel_log = {sel_log[6:0], s};
                cx1 = op_x1; cy1 = op_y1; cx2 = op_x2; cy2 = op_y2; cp = op_p;
                last_x2 = op_x2; last_y2 = op_y2;
                x1 = int'(cx1); y1 = int'(cy1); x2 = int'(cx2); y2 = int'(cy2);
                inf = 1'b0;
                l = 0;
                if (s) begin
                    x2 = x1;
                    if (y1 == 0) inf = 1'b1;
                    else l = md((3 * x1 * x1 + 2) * inv(2 * y1));
                end else begin
                    if (x1 == x2) inf = 1'b1;
                    else l = md((y2 - y1) * inv(x2 - x1));
                end
                x3 = md(l * l - x1 - x2);
                y3 = md(l * (x1 - x3) - y1);
                lat = $urandom_range(20, min_lat);
                repeat (lat - 1) @(negedge clk);
                if (!in_rst_test) begin
                    if (op_x1 !== cx1 || op_y1 !== cy1 || op_p !== cp || op_sel !== s) stab_err++;
                    if (!s && (op_x2 !== cx2 || op_y2 !== cy2)) stab_err++;
                end
                op_x3 = inf ? '0 : N'(x3);
                op_y3 = inf ? '0 : N'(y3);
                op_inf = inf;
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
                resp_busy = 0;
            end
        end
    end

    task automatic pulse_start(input logic [N-1:0] kv);
        @(negedge clk);
        k_in  = kv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output bit ok);
        ok = 0;
        for (int c = 0; c < 4000; c++) begin
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    typedef struct {
        logic [N-1:0] k;
        int           ex, ey, einf;
        int           ereq;
        logic [7:0]   esel;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok, saw_done;
        reset = 1'b1;
        start = 1'b0;
        spur_done = 1'b0;
        k_in  = '0;
        p_in  = 8'd17;
        px_in = 8'd5;
        py_in = 8'd1;

        vecs[0] = '{k: 8'd1,  ex: 5,  ey: 1,  einf: 0, ereq: 0, esel: 8'b0};
        vecs[1] = '{k: 8'd2,  ex: 6,  ey: 3,  einf: 0, ereq: 1, esel: 8'b1};
        vecs[2] = '{k: 8'd3,  ex: 10, ey: 6,  einf: 0, ereq: 2, esel: 8'b10};
        vecs[3] = '{k: 8'd4,  ex: 3,  ey: 1,  einf: 0, ereq: 2, esel: 8'b11};
        vecs[4] = '{k: 8'd5,  ex: 9,  ey: 16, einf: 0, ereq: 3, esel: 8'b110};
        vecs[5] = '{k: 8'd18, ex: 5,  ey: 16, einf: 0, ereq: 5, esel: 8'b11101};
        vecs[6] = '{k: 8'd19, ex: 0,  ey: 0,  einf: 1, ereq: 5, esel: 8'b11101};
        vecs[7] = '{k: 8'd0,  ex: 0,  ey: 0,  einf: 1, ereq: 0, esel: 8'b0};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_op_req", int'(op_req), 0);
        chk("rst_q", int'({q_inf, qx, qy, op_sel}), 0);
        chk("rst_ops", int'(op_x1 | op_y1 | op_x2 | op_y2 | op_p), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req_cnt = 0;
            sel_log = '0;
            stab_err = 0;
            pulse_start(vecs[i].k);
            chk($sformatf("busy_k%0d", vecs[i].k), int'(busy), 1);
            chk($sformatf("op_p_k%0d", vecs[i].k), int'(op_p), 17);
            wait_done($sformatf("k%0d", vecs[i].k), ok);
            if (ok) begin
                chk($sformatf("qx_k%0d", vecs[i].k), int'(qx), vecs[i].ex);
                chk($sformatf("qy_k%0d", vecs[i].k), int'(qy), vecs[i].ey);
                chk($sformatf("qinf_k%0d", vecs[i].k), int'(q_inf), vecs[i].einf);
                chk($sformatf("reqs_k%0d", vecs[i].k), req_cnt, vecs[i].ereq);
                chk($sformatf("sels_k%0d", vecs[i].k), int'(sel_log), int'(vecs[i].esel));
                chk($sformatf("stable_k%0d", vecs[i].k), stab_err, 0);
                chk($sformatf("busy_at_done_k%0d", vecs[i].k), int'(busy), 0);
                if (vecs[i].k == 8'd3) begin
                    chk("k3_add_x2", int'(last_x2), 5);
                    chk("k3_add_y2", int'(last_y2), 1);
                end
                @(negedge clk);
                chk($sformatf("done_pulse_k%0d", vecs[i].k), int'(done), 0);
            end
        end

        // Start while busy is ignored; computation of 2P continues undisturbed.
        req_cnt = 0;
        pulse_start(8'd2);
        repeat (2) @(negedge clk);
        chk("busy_mid", int'(busy), 1);
        k_in  = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart", ok);
        if (ok) begin
            chk("restart_qx", int'(qx), 6);
            chk("restart_qy", int'(qy), 3);
            chk("restart_reqs", req_cnt, 1);
        end

        // Spurious op_done in IDLE leaves Q and state untouched.
        repeat (3) @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        saw_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || op_req) saw_done = 1;
        end
        chk("spur_activity", int'(saw_done), 0);
        chk("spur_qx", int'(qx), 6);
        chk("spur_qy", int'(qy), 3);

        // Reset while waiting on a doubling; the late response must be ignored.
        in_rst_test = 1;
        min_lat = 10;
        pulse_start(8'd2);
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            if (op_req === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_test_req_seen", int'(ok), 1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_op_req", int'(op_req), 0);
        chk("midrst_q", int'({q_inf, qx, qy}), 0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 100 && resp_busy; c++) begin
            @(negedge clk);
            if (done || busy || op_req) saw_done = 1;
        end
        repeat (3) begin
            @(negedge clk);
            if (done || busy || op_req) saw_done = 1;
        end
        chk("late_done_ignored", int'(saw_done), 0);
        in_rst_test = 0;
        min_lat = 1;
        req_cnt = 0;
        stab_err = 0;
        pulse_start(8'd2);
        wait_done("post_rst", ok);
        if (ok) begin
            chk("post_rst_qx", int'(qx), 6);
            chk("post_rst_qy", int'(qy), 3);
            chk("post_rst_qinf", int'(q_inf), 0);
            chk("post_rst_reqs", req_cnt, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
